// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the fetch-queue entry type used by the fetch front end.
package riscv_pkg;
    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} between instruction memory and IF/ID.
module fetch_queue import riscv_pkg::*; #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: fetch PC, imem requests, response queue and IF/ID register.
// Defining FETCH_PERF_CNT_EN adds the stall_cyc / redirect_cnt performance counters.
module fetch_unit import riscv_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] stall_cyc,
    output logic [XLEN-1:0] redirect_cnt
`endif
);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] pcf;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   kill;
    logic [CW-1:0]   qcount;
    logic [CW:0]     occupancy;
    logic            rsp;
    logic            accept;
    logic            issue;
    logic            bypass;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    fetch_entry_t    q_head;
    fetch_entry_t    rsp_entry;

    assign occupancy = {1'b0, outstanding} + {1'b0, qcount};
    assign issue     = rst_n && !StallF && !PCSrcE && (occupancy < (CW+1)'(QDEPTH));
    assign imem_req  = issue;
    assign imem_addr = pcf;

    assign rsp     = imem_rvalid && (outstanding != '0);
    assign accept  = rsp && !PCSrcE && (kill == '0);
    assign q_empty = (qcount == '0);
    assign q_pop   = !FlushD && !StallD && !q_empty;
    assign bypass  = accept && q_empty && !StallD && !FlushD;
    assign q_push  = accept && !bypass;

    // Accepted responses always belong to the current stream, whose outstanding
    // requests are contiguous and end at PCF-4, so the oldest one is at PCF-4*outstanding.
    always_comb begin
        rsp_entry.pc    = pcf - (XLEN'(outstanding) << 2);
        rsp_entry.instr = imem_rdata;
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (PCSrcE),
        .push      (q_push),
        .push_data (rsp_entry),
        .pop       (q_pop),
        .head      (q_head),
        .count     (qcount)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf         <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
        end else begin
            if (PCSrcE)     pcf <= PCTargetE;
            else if (issue) pcf <= pcf + 32'd4;
            outstanding <= outstanding + CW'(issue) - CW'(rsp);
            if (PCSrcE)                  kill <= outstanding - CW'(rsp);
            else if (rsp && kill != '0)  kill <= kill - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= 32'd4;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD <= InstrD;
        end else if (q_pop) begin
            InstrD   <= q_head.instr;
            PCD      <= q_head.pc;
            PCPlus4D <= q_head.pc + 32'd4;
            ValidD   <= 1'b1;
        end else if (bypass) begin
            InstrD   <= rsp_entry.instr;
            PCD      <= rsp_entry.pc;
            PCPlus4D <= rsp_entry.pc + 32'd4;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc    <= '0;
            redirect_cnt <= '0;
        end else begin
            stall_cyc    <= stall_cyc + XLEN'(StallF);
            redirect_cnt <= redirect_cnt + XLEN'(PCSrcE);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a fetch-stream reference model predicts requests and IF/ID contents.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int unsigned QD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int unsigned due; int unsigned epoch; } mreq_t;

    exp_t        sb[$];      // expected IF/ID entries of the current fetch stream, oldest first
    mreq_t       mem_q[$];   // requests pending inside the memory model
    int unsigned cyc = 0, epoch = 0, cur_pending = 0, lat = 1, jit = 0;
    logic [31:0] model_pc = RPC;
    int          tests = 0, fails = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic sf, input logic sd, input logic fd, input logic br,
                        input logic [31:0] tgt);
        int  pend, cp;
        logic exp_req;
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        pend = mem_q.size();
        cp   = cur_pending;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q[0].addr);
            if (mem_q[0].epoch == epoch) cur_pending--;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = br; PCTargetE = tgt;
        // Requests in flight plus responses waiting for IF/ID must stay below QD.
        exp_req = !sf && !br && ((pend + (sb.size() - cp)) < QD);
        #1;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) begin
            mem_q.push_back('{addr: imem_addr, due: cyc + lat + (jit != 0 ? $urandom_range(0, 2) : 0),
                              epoch: epoch});
            cur_pending++;
        end
        if (exp_req) begin
            check("imem_addr", imem_addr, model_pc);
            sb.push_back('{pc: model_pc, instr: instr_of(model_pc)});
            model_pc = model_pc + 32'd4;
        end
        if (br) begin
            model_pc = tgt;
            sb.delete();
            epoch++;
            cur_pending = 0;
        end
    endtask

    task automatic do_reset(input int unsigned ncyc);
        @(negedge clk);
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_InstrD", InstrD, NOP);
        check("rst_PCD", PCD, 32'd0);
        check("rst_PCPlus4D", PCPlus4D, 32'd4);
        check("rst_ValidD", 32'(ValidD), 32'd0);
        check("rst_imem_addr", imem_addr, RPC);
        mem_q.delete();
        sb.delete();
        cur_pending = 0;
        epoch++;
        model_pc = RPC;
        repeat (ncyc) @(negedge clk);
    endtask

    // Monitor: every edge that loads a real instruction into IF/ID must pop the scoreboard head.
    initial begin
        logic        h, in_rst, p_valid;
        logic [31:0] p_instr, p_pc;
        exp_t        e;
        p_instr = NOP; p_pc = '0; p_valid = 1'b0;
        forever begin
            @(posedge clk);
            h      = StallD && !FlushD;
            in_rst = !rst_n;
            #1;
            if (!in_rst) begin
                if (h) begin
                    check("hold_PCD", PCD, p_pc);
                    check("hold_InstrD", InstrD, p_instr);
                    check("hold_ValidD", 32'(ValidD), 32'(p_valid));
                end else if (ValidD) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_valid: got PCD %h expected no instruction (cycle %0d)", PCD, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("PCD", PCD, e.pc);
                        check("InstrD", InstrD, e.instr);
                        check("PCPlus4D", PCPlus4D, e.pc + 32'd4);
                    end
                end else begin
                    check("bubble_InstrD", InstrD, NOP);
                end
            end
            p_instr = InstrD; p_pc = PCD; p_valid = ValidD;
        end
    end

    initial begin
        logic        sf, sd, fd, br;
        logic [31:0] tgt;
        do_reset(2);

        // Straight-line fetch, 1-cycle memory.
        lat = 1; jit = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0);
        // Front-end and decode stall together, then release.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0);

        // Redirect with stale requests in flight, 3-cycle memory.
        lat = 3;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0);
        step(0, 0, 1, 1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0);

        // Redirect during StallF, then FlushD with StallD.
        lat = 1;
        step(1, 0, 1, 1, 32'h0000_0200);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0);
        step(0, 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0);

        // PC wrap-around.
        step(0, 0, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0);

        // Randomized hazards and memory latency, with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) begin
                lat = $urandom_range(1, 3);
                jit = $urandom_range(0, 1);
            end
            if (i == 700) do_reset(2);
            sf  = ($urandom_range(0, 99) < 20);
            sd  = ($urandom_range(0, 99) < 20);
            fd  = ($urandom_range(0, 99) < 5);
            br  = ($urandom_range(0, 99) < 4);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000C);
            if (br) fd = 1'b1;
            step(sf, sd, fd, br, tgt);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
